// File: rtl/us_scan_array.sv
// Round-robin ultrasonic range-finder scanner: triggers one masked channel at a
// time, times its echo in microseconds, converts to millimetres and publishes a
// per-channel distance, obstacle flag and timeout flag.
module us_scan_array #(
  parameter int N_CH      = 3,
  parameter int DIST_W    = 16,
  parameter int US_DIV    = 50,
  parameter int TRIG_CYC  = 500,
  parameter int WAIT_US   = 1000,
  parameter int MAX_US    = 38000,
  parameter int GUARD_US  = 10000,
  parameter int THRESH_MM = 70
) (
  input  logic                     clk_50M,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_CH-1:0]          ch_mask,
  input  logic [N_CH-1:0]          echo,
  output logic [N_CH-1:0]          trig,
  output logic [N_CH*DIST_W-1:0]   distance_out,
  output logic [N_CH-1:0]          op,
  output logic [N_CH-1:0]          tout,
  output logic [N_CH-1:0]          valid,
  output logic                     busy
);

  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CYC_MAX  = (US_DIV > TRIG_CYC) ? US_DIV : TRIG_CYC;
  localparam int CYC_W    = $clog2(CYC_MAX + 1);
  localparam int US_MAX_A = (WAIT_US > MAX_US) ? WAIT_US : MAX_US;
  localparam int US_MAX   = (US_MAX_A > GUARD_US) ? US_MAX_A : GUARD_US;
  localparam int US_W     = $clog2(US_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, TRIG, WAIT_RISE, MEASURE, UPDATE, GUARD
  } state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   cur;
  logic [CH_W-1:0]   pick;
  logic [CH_W-1:0]   idx;
  logic              found;
  logic [CYC_W-1:0]  cyc;
  logic [US_W-1:0]   us_cnt;
  logic [N_CH-1:0]   echo_p0, echo_p1, echo_p2;
  logic              enter, tick, rise, lvl, upd_to;
  logic [DIST_W-1:0] mm_w;

  // Echo time (us) to millimetres: (us * 11239) >> 16, truncated, clamped to the slot width.
  function automatic logic [DIST_W-1:0] us_to_mm(input logic [US_W-1:0] us);
    logic [47:0] mm;
    mm = (48'(us) * 48'd11239) >> 16;
    if (|(mm >> DIST_W)) return '1;
    return mm[DIST_W-1:0];
  endfunction

  assign enter = (state_nxt != state);
  assign tick  = (state != TRIG) && (cyc == CYC_W'(US_DIV - 1));
  assign lvl   = echo_p1[cur];
  assign rise  = echo_p1[cur] & ~echo_p2[cur];
  assign mm_w  = us_to_mm(us_cnt);
  assign trig  = (state == TRIG) ? (N_CH'(1) << cur) : '0;
  assign busy  = (state != IDLE);

  // Two-flop synchroniser on the raw echo lines; echo_p2 is the previous synced value for edge detect.
  always_ff @(posedge clk_50M) begin
    echo_p0 <= echo;
    echo_p1 <= echo_p0;
    echo_p2 <= echo_p1;
  end

  // Round-robin search: first masked channel strictly after the last serviced one.
  always_comb begin
    pick  = cur;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = CH_W'((int'(cur) + i) % N_CH);
      if (!found && ch_mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state logic; upd_to marks an UPDATE entered through a timeout.
  always_comb begin
    state_nxt = state;
    upd_to    = 1'b0;
    case (state)
      IDLE:      if (enable && |ch_mask) state_nxt = SELECT;
      SELECT:    state_nxt = found ? TRIG : IDLE;
      TRIG:      if (cyc == CYC_W'(TRIG_CYC - 1)) state_nxt = WAIT_RISE;
      WAIT_RISE: begin
        if (rise) begin
          state_nxt = MEASURE;
        end else if (tick && us_cnt == US_W'(WAIT_US - 1)) begin
          state_nxt = UPDATE;
          upd_to    = 1'b1;
        end
      end
      MEASURE: begin
        if (!lvl) begin
          state_nxt = UPDATE;
        end else if (tick && us_cnt == US_W'(MAX_US - 1)) begin
          state_nxt = UPDATE;
          upd_to    = 1'b1;
        end
      end
      UPDATE:    state_nxt = GUARD;
      GUARD: begin
        if (tick && us_cnt == US_W'(GUARD_US - 1))
          state_nxt = (enable && |ch_mask) ? SELECT : IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // State register, channel pointer, and cycle/us counters that restart on every state entry.
  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cur    <= CH_W'(N_CH - 1);
      cyc    <= '0;
      us_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == SELECT && found) cur <= pick;
      if (enter || tick) cyc <= '0;
      else               cyc <= cyc + 1'b1;
      if (enter)
        us_cnt <= '0;
      else if (tick && (state == WAIT_RISE || state == MEASURE || state == GUARD))
        us_cnt <= us_cnt + 1'b1;
    end
  end

  // Result publication: slot, flags and valid pulse all change together as UPDATE is entered.
  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      distance_out <= '1;
      op           <= '0;
      tout         <= '0;
      valid        <= '0;
    end else begin
      valid <= '0;
      if (state_nxt == UPDATE && state != UPDATE) begin
        distance_out[int'(cur)*DIST_W +: DIST_W] <= upd_to ? '1 : mm_w;
        tout[cur]  <= upd_to;
        op[cur]    <= !upd_to && (48'(mm_w) < 48'(THRESH_MM));
        valid[cur] <= 1'b1;
      end
    end
  end

endmodule

// File: doc/us_scan_array.md
US_SCAN_ARRAY -- requirements
Module: us_scan_array

Interface
REQ-001 Parameter N_CH, default 3: number of ultrasonic channels, 1..8.
REQ-002 Parameter DIST_W, default 16: per-channel distance width in mm.
REQ-003 Parameter US_DIV, default 50: clk_50M cycles per microsecond tick.
REQ-004 Parameter TRIG_CYC, default 500: trigger pulse width in cycles.
REQ-005 Parameter WAIT_US, default 1000: maximum wait for echo rise in µs.
REQ-006 Parameter MAX_US, default 38000: maximum echo-high duration in µs.
REQ-007 Parameter GUARD_US, default 10000: dead time between channels in µs.
REQ-008 Parameter THRESH_MM, default 70: obstacle threshold in mm.
REQ-009 clk_50M  input  1  sole clock; all logic rising-edge.
REQ-010 reset  input  1  asynchronous, active-low reset.
REQ-011 enable  input  1  scanning permitted while high.
REQ-012 ch_mask  input  N_CH  a high bit includes that channel in the scan.
REQ-013 echo  input  N_CH  raw echo lines, asynchronous.
REQ-014 trig  output  N_CH  trigger pulses, at most one bit high at any time.
REQ-015 distance_out  output  N_CH*DIST_W  latest distance per channel; channel k occupies bits [k*DIST_W +: DIST_W].
REQ-016 op  output  N_CH  obstacle flag per channel.
REQ-017 tout  output  N_CH  the last measurement of that channel timed out.
REQ-018 valid  output  N_CH  one-cycle pulse when that channel's outputs update.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 Each echo bit SHALL pass through a 2-FF synchroniser; all echo references below mean the synchronised value.
REQ-021 A µs tick SHALL occur every US_DIV cycles; the tick counter SHALL clear on every state entry.
REQ-022 FSM states SHALL be IDLE, SELECT, TRIG, WAIT_RISE, MEASURE, UPDATE, GUARD.
REQ-023 IDLE -> SELECT when enable=1 and ch_mask!=0; otherwise IDLE holds, all trig=0.
REQ-024 SELECT SHALL pick the next masked channel in round-robin order after the last serviced channel (wrap N_CH-1 -> 0); first pick after reset starts at channel 0; -> TRIG, 1 cycle.
REQ-025 TRIG SHALL drive trig[cur]=1 for exactly TRIG_CYC cycles, then -> WAIT_RISE.
REQ-026 WAIT_RISE SHALL require a low-to-high echo transition; an echo already high on entry SHALL NOT count until it falls and rises again.
REQ-027 WAIT_RISE -> MEASURE on rising edge, with the µs counter cleared; -> UPDATE with timeout after WAIT_US ticks without a rise.
REQ-028 MEASURE SHALL count ticks while echo=1; on echo fall -> UPDATE with echo_us=count; on reaching MAX_US -> UPDATE with timeout.
REQ-029 Distance computation: mm = (echo_us * 11239) >> 16, computed at least 32 bits wide, truncated, saturated to 2^DIST_W-1.
REQ-030 UPDATE (1 cycle): on a valid measurement, write mm into the channel slot, tout=0, op = (mm < THRESH_MM); on timeout, write all-ones, tout=1, op=0; pulse valid[cur]; -> GUARD.
REQ-031 GUARD SHALL wait GUARD_US ticks, then -> SELECT if enable=1 and ch_mask!=0, else -> IDLE.
REQ-032 Clearing enable mid-scan SHALL NOT abort the current channel; the FSM returns to IDLE after GUARD.
REQ-033 ch_mask SHALL be sampled only in IDLE/GUARD exit and SELECT; changes mid-channel do not affect that channel.
REQ-034 Outputs of channels not being serviced SHALL hold their last values.

Reset
REQ-035 On reset=0, asynchronously: state=IDLE, trig=0, valid=0, busy=0, op=0, tout=0, distance_out all-ones, round-robin pointer so that channel 0 is next.
REQ-036 Reset asserted mid-TRIG SHALL drop trig in the same instant, not at the next edge.

Verification
REQ-037 N_CH=3, mask=3'b111, echo0 high 1000 µs after trigger -> valid[0] pulse, distance 171, op[0]=0, tout[0]=0.
REQ-038 echo1 high 300 µs -> distance slot 1 = 51, op[1]=1; trig order observed 0,1,2,0 with GUARD gaps of 10000 µs.
REQ-039 No echo on channel 2 -> UPDATE after 1000 µs, slot 2=16'hFFFF, tout[2]=1, op[2]=0.
REQ-040 mask=3'b101 -> trig[1] never asserts; order 0,2,0; mask=0 with enable=1 -> busy=0, no triggers.
REQ-041 DIST_W=8, echo 2000 µs (raw 342) -> slot=8'hFF; echo held high >38000 µs -> timeout.
REQ-042 reset pulsed low mid-TRIG on channel 1 -> trig=0 immediately, all outputs at reset values, next trigger on channel 0.
